// File: rtl/avrspi_pkg.sv
// Shared definitions for the AVR<->FPGA register-link SPI master: FSM state encodings,
// link register numbers and parameter floors.
package avrspi_pkg;

   localparam int unsigned HALF_DIV_MIN = 2;
   localparam int unsigned HALF_DIV_MAX = 255;
   localparam int unsigned CS_SETUP_MIN = 4;
   localparam int unsigned CS_GAP_MIN   = 3;

   typedef logic [2:0] avrspi_state_t;

   localparam avrspi_state_t StIdle  = 3'd0;
   localparam avrspi_state_t StAddr  = 3'd1;
   localparam avrspi_state_t StSetup = 3'd2;
   localparam avrspi_state_t StData  = 3'd3;
   localparam avrspi_state_t StGap   = 3'd4;

   localparam logic [7:0] SD_CS0        = 8'h57;
   localparam logic [7:0] SD_CS1        = 8'h5F;
   localparam logic [7:0] FLASH_LOADDR  = 8'hF0;
   localparam logic [7:0] FLASH_MIDADDR = 8'hF1;
   localparam logic [7:0] FLASH_HIADDR  = 8'hF2;
   localparam logic [7:0] FLASH_DATA    = 8'hF3;
   localparam logic [7:0] FLASH_CTRL    = 8'hF4;
   localparam logic [7:0] SCR_LOADDR    = 8'h40;
   localparam logic [7:0] SCR_HIADDR    = 8'h41;
   localparam logic [7:0] SCR_CHAR      = 8'h44;
   localparam logic [7:0] SCR_MODE      = 8'h4E;

   // Down-counters count N cycles by loading N-1 and stopping at zero.
   function automatic logic [7:0] reload_value(input int unsigned cycles);
      return 8'(cycles - 1);
   endfunction

endpackage

// File: rtl/avrspi_halfbit_tick.sv
// Half-bit timebase: an 8-bit loadable down-counter that ticks once every HALF_DIV cycles
// while enabled.
module avrspi_halfbit_tick
   import avrspi_pkg::*;
#(
   parameter int unsigned HALF_DIV = 4
) (
   input  logic i_fclk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_load,
   output logic o_tick
);

   localparam logic [7:0] Reload = reload_value(HALF_DIV);

   logic [7:0] r_cnt;

   always_ff @(posedge i_fclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= Reload;
      end else if (i_load) begin
         r_cnt <= Reload;
      end else if (i_en) begin
         r_cnt <= (r_cnt == 8'd0) ? Reload : r_cnt - 8'd1;
      end
   end

   assign o_tick = i_en && (r_cnt == 8'd0);

endmodule

// File: rtl/avrspi_master.sv
// SPI master for the AVR<->FPGA register link: address byte with CS high, data byte with CS low.
// Define AVRSPI_ADDR_SKIP_EN to skip the address phase when the register number repeats.
module avrspi_master
   import avrspi_pkg::*;
#(
   parameter int unsigned HALF_DIV = 4,
   parameter int unsigned CS_SETUP = 4,
   parameter int unsigned CS_GAP   = 4
) (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       spics_n,
   output logic       spick,
   output logic       spido,
   input  logic       spidi
);

   localparam logic [7:0] SetupLoad = reload_value(CS_SETUP);
   localparam logic [7:0] GapLoad   = reload_value(CS_GAP);

   avrspi_state_t r_state;
   logic [7:0]    r_addr_sh;
   logic [7:0]    r_data_sh;
   logic [7:0]    r_miso_sh;
   logic [7:0]    r_wait_cnt;
   logic [2:0]    r_bit_cnt;
   logic          r_spics_n;
   logic          r_spick;
   logic          r_spido;
   logic          r_rsp_valid;
   logic [7:0]    r_rsp_data;

   logic w_tick_en;
   logic w_tick;
   logic w_skip_addr;

   assign w_tick_en = (r_state == StAddr) || (r_state == StData);

   avrspi_halfbit_tick #(
      .HALF_DIV (HALF_DIV)
   ) u_tick (
      .i_fclk  (fclk),
      .i_rst_n (rst_n),
      .i_en    (w_tick_en),
      .i_load  (!w_tick_en),
      .o_tick  (w_tick)
   );

`ifdef AVRSPI_ADDR_SKIP_EN
   logic [7:0] r_last_addr;
   logic       r_last_vld;

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_addr <= 8'h00;
         r_last_vld  <= 1'b0;
      end else if ((r_state == StIdle) && cmd_valid) begin
         r_last_addr <= cmd_addr;
         r_last_vld  <= 1'b1;
      end
   end

   // The responder keeps its register number while no SCK edge occurs with CS high.
   assign w_skip_addr = r_last_vld && (r_last_addr == cmd_addr);
`else
   assign w_skip_addr = 1'b0;
`endif

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_addr_sh   <= 8'h00;
         r_data_sh   <= 8'h00;
         r_miso_sh   <= 8'h00;
         r_wait_cnt  <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_spics_n   <= 1'b1;
         r_spick     <= 1'b0;
         r_spido     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 8'h00;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (cmd_valid) begin
                  r_addr_sh <= cmd_addr;
                  r_data_sh <= cmd_data;
                  r_bit_cnt <= 3'd0;
                  r_spick   <= 1'b0;
                  if (w_skip_addr) begin
                     r_state    <= StSetup;
                     r_spics_n  <= 1'b0;
                     r_wait_cnt <= SetupLoad;
                  end else begin
                     r_state <= StAddr;
                     r_spido <= cmd_addr[7];
                  end
               end
            end
            StAddr: begin
               if (w_tick) begin
                  if (!r_spick) begin
                     r_spick <= 1'b1;
                  end else begin
                     r_spick   <= 1'b0;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_state    <= StSetup;
                        r_spics_n  <= 1'b0;
                        r_wait_cnt <= SetupLoad;
                     end else begin
                        r_spido   <= r_addr_sh[6];
                        r_addr_sh <= {r_addr_sh[6:0], 1'b0};
                     end
                  end
               end
            end
            StSetup: begin
               if (r_wait_cnt == 8'd0) begin
                  r_state <= StData;
                  r_spido <= r_data_sh[7];
               end else begin
                  r_wait_cnt <= r_wait_cnt - 8'd1;
               end
            end
            StData: begin
               if (w_tick) begin
                  if (!r_spick) begin
                     r_spick   <= 1'b1;
                     r_miso_sh <= {r_miso_sh[6:0], spidi};
                  end else begin
                     r_spick   <= 1'b0;
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (r_bit_cnt == 3'd7) begin
                        r_state     <= StGap;
                        r_spics_n   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_miso_sh;
                        r_wait_cnt  <= GapLoad;
                     end else begin
                        r_spido   <= r_data_sh[6];
                        r_data_sh <= {r_data_sh[6:0], 1'b0};
                     end
                  end
               end
            end
            StGap: begin
               if (r_wait_cnt == 8'd0) begin
                  r_state <= StIdle;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 8'd1;
               end
            end
            default: begin
               r_state   <= StIdle;
               r_spics_n <= 1'b1;
               r_spick   <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = (r_state == StIdle);
   assign busy      = (r_state != StIdle);
   assign spics_n   = r_spics_n;
   assign spick     = r_spick;
   assign spido     = r_spido;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

endmodule
